// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, reads program bytes over
// req/ack, executes NOP/JMP/JZ/HLT itself and hands all other opcodes to the decoder.
module fetch_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pc,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  input  logic [7:0] mem_data,
  input  logic       mem_ack,
  input  logic       zero,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic       halted,
  output logic [2:0] fsm_state
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h1;
  localparam logic [3:0] OP_JZ  = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    START   = 3'd0,
    FETCH   = 3'd1,
    OPERAND = 3'd2,
    ISSUE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Handshakes: mem_data is consumed only in a cycle with mem_req && mem_ack;
  // instr is transferred on any rising edge where instr_valid && instr_ready,
  // and instr holds its value for as long as instr_valid is high.

  state_t     state;
  state_t     state_next;
  logic       jz_pending;
  logic       jz_next;
  logic [7:0] instr_next;
  logic [3:0] opcode;

  assign opcode    = mem_data[7:4];
  assign mem_addr  = pc;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= START;
      instr      <= 8'h00;
      jz_pending <= 1'b0;
    end else begin
      state      <= state_next;
      instr      <= instr_next;
      jz_pending <= jz_next;
    end
  end

  // The PC has no enable, so every cycle that must not advance it reloads pc.
  always_comb begin
    state_next  = state;
    instr_next  = instr;
    jz_next     = jz_pending;
    pc_load     = 1'b1;
    pc_target   = pc;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      START: begin
        pc_target  = 8'h00;
        state_next = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          case (opcode)
            OP_NOP: pc_load = 1'b0;
            OP_JMP, OP_JZ: begin
              pc_load    = 1'b0;
              jz_next    = (opcode == OP_JZ);
              state_next = OPERAND;
            end
            OP_HLT: state_next = HALT;
            default: begin
              pc_load    = 1'b0;
              instr_next = mem_data;
              state_next = ISSUE;
            end
          endcase
        end
      end
      OPERAND: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          // Taken jumps load the operand byte; untaken JZ steps past it.
          if (!jz_pending || zero) begin
            pc_target = mem_data;
          end else begin
            pc_load = 1'b0;
          end
          state_next = FETCH;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = START;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register and a wait-state ROM around the
// DUT and checks fetch addresses, issued opcodes and timing against an ISA-level model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_reg = 8'hA7;
  logic       pc_load;
  logic [7:0] pc_target;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_data;
  logic       mem_ack;
  logic       zero = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       halted;
  logic [2:0] fsm_state;

  logic [7:0] rom [256];
  int         wait_states = 0;
  int         wait_cnt = 0;
  logic       ready_en = 1'b1;
  logic       ready_rand = 1'b0;
  logic       rnd_ready = 1'b1;
  logic [7:0] junk = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  // Observations collected by the monitor
  logic [7:0] got_addr_q[$];
  logic [7:0] got_instr_q[$];
  int         pc_err = 0;
  int         instr_err = 0;
  int         addr_err = 0;
  logic       prev_wait = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_pc = 8'h00;
  logic [7:0] prev_instr = 8'h00;

  // Expectations from the ISA-level model
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_instr_q[$];
  logic [7:0] m_pc;
  bit         m_halt;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc(pc_reg), .pc_load(pc_load), .pc_target(pc_target),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_ack(mem_ack),
    .zero(zero), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted), .fsm_state(fsm_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) pc_reg <= pc_load ? pc_target : pc_reg + 8'd1;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    #2;
    junk      <= 8'($urandom_range(0, 255));
    rnd_ready <= 1'($urandom_range(0, 1));
  end

  assign mem_ack     = mem_req && (wait_cnt >= wait_states);
  assign mem_data    = mem_ack ? rom[mem_addr] : junk;
  assign instr_ready = ready_rand ? rnd_ready : ready_en;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      got_addr_q.delete();
      got_instr_q.delete();
      pc_err     <= 0;
      instr_err  <= 0;
      addr_err   <= 0;
      prev_wait  <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (mem_addr !== pc_reg) addr_err <= addr_err + 1;
      if (prev_wait && pc_reg !== prev_pc) pc_err <= pc_err + 1;
      if (prev_stall && (!instr_valid || instr !== prev_instr)) instr_err <= instr_err + 1;
      if (mem_req && mem_ack) got_addr_q.push_back(mem_addr);
      if (instr_valid && instr_ready) got_instr_q.push_back(instr);
      prev_wait  <= mem_req && !mem_ack;
      prev_stall <= instr_valid && !instr_ready;
      prev_pc    <= pc_reg;
      prev_instr <= instr;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_run(input logic z, input int max_fetch);
    logic [7:0] p;
    logic [7:0] op;
    int n;
    exp_addr_q.delete();
    exp_instr_q.delete();
    m_halt = 0;
    p = 8'h00;
    n = 0;
    while (!m_halt && n < max_fetch) begin
      op = rom[p];
      exp_addr_q.push_back(p);
      n++;
      if (op[7:4] == 4'h0) begin
        p = p + 8'd1;
      end else if (op[7:4] == 4'h1 || op[7:4] == 4'h2) begin
        exp_addr_q.push_back(p + 8'd1);
        n++;
        if (op[7:4] == 4'h1 || z) p = rom[p + 8'd1];
        else p = p + 8'd2;
      end else if (op[7:4] == 4'hF) begin
        m_halt = 1;
      end else begin
        exp_instr_q.push_back(op);
        p = p + 8'd1;
      end
    end
    m_pc = p;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (halted) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fill_halt();
    wait_states = 0;
    ready_rand = 0;
    ready_en = 1;
    @(posedge clk);
    #2 rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got req=%b valid=%b halted=%b, want 0 0 0", mem_req, instr_valid, halted);
      end
      n_checks++;
      if (pc_load !== 1'b1 || pc_target !== 8'h00 || instr !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_pc_drive: got load=%b target=%h instr=%h, want 1 00 00", pc_load, pc_target, instr);
      end
      @(posedge clk);
    end
    n_checks++;
    if (pc_reg !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want 00", pc_reg);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || pc_load !== 1'b1 || pc_target !== 8'h00) begin
      n_fail++;
      $display("FAIL start_cycle: got req=%b load=%b target=%h, want 0 1 00", mem_req, pc_load, pc_target);
    end
    @(negedge clk);
    n_checks++;
    if (pc_reg !== 8'h00 || mem_req !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: got pc=%h req=%b valid=%b halted=%b, want 00 1 0 0", pc_reg, mem_req, instr_valid, halted);
    end
  endtask

  task automatic test_straight_line();
    int cyc;
    bit ok;
    fill_halt();
    rom[0] = 8'h30; rom[1] = 8'h00; rom[2] = 8'h45;
    wait_states = 0;
    ready_en = 1;
    zero = 0;
    model_run(1'b0, 64);
    do_reset();
    wait_halt(200, cyc, ok);
    n_checks++;
    if (!ok || got_instr_q.size() != 2 || got_instr_q[0] !== 8'h30 || got_instr_q[1] !== 8'h45) begin
      n_fail++;
      $display("FAIL straight_instrs: got halted=%b count=%0d, want halt with 30,45", ok, got_instr_q.size());
    end
    n_checks++;
    if (got_addr_q != exp_addr_q) begin
      n_fail++;
      $display("FAIL straight_addrs: got %p want %p", got_addr_q, exp_addr_q);
    end
    n_checks++;
    if (pc_reg !== 8'h03) begin
      n_fail++;
      $display("FAIL straight_pc: got %h want 03", pc_reg);
    end
    n_checks++;
    if (cyc != 2 + exp_addr_q.size() + exp_instr_q.size()) begin
      n_fail++;
      $display("FAIL straight_latency: got %0d cycles want %0d", cyc, 2 + exp_addr_q.size() + exp_instr_q.size());
    end
  endtask

  task automatic test_jump();
    int cyc;
    bit ok;
    logic [2:0] st;
    fill_halt();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h80; rom[8'h80] = 8'hF0;
    wait_states = 0;
    model_run(1'b0, 64);
    do_reset();
    wait_halt(200, cyc, ok);
    n_checks++;
    if (!ok || got_addr_q != exp_addr_q) begin
      n_fail++;
      $display("FAIL jump_addrs: got halted=%b %p want %p", ok, got_addr_q, exp_addr_q);
    end
    n_checks++;
    if (cyc != 2 + exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL jump_latency: got %0d cycles want %0d", cyc, 2 + exp_addr_q.size());
    end
    st = fsm_state;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || pc_reg !== 8'h80 || mem_req !== 1'b0 || fsm_state !== st) begin
        n_fail++;
        $display("FAIL halt_hold: cycle %0d got halted=%b pc=%h req=%b, want 1 80 0", i, halted, pc_reg, mem_req);
      end
    end
  endtask

  task automatic test_cond_jump();
    int cyc;
    bit ok;
    for (int z = 0; z < 2; z++) begin
      fill_halt();
      rom[0] = 8'h20; rom[1] = 8'h40;
      wait_states = 0;
      zero = 1'(z);
      model_run(1'(z), 64);
      do_reset();
      wait_halt(200, cyc, ok);
      n_checks++;
      if (!ok || pc_reg !== (z == 1 ? 8'h40 : 8'h02) || pc_reg !== m_pc) begin
        n_fail++;
        $display("FAIL jz_pc_z%0d: got halted=%b pc=%h want %h", z, ok, pc_reg, m_pc);
      end
      n_checks++;
      if (got_addr_q != exp_addr_q || cyc != 2 + exp_addr_q.size()) begin
        n_fail++;
        $display("FAIL jz_seq_z%0d: got %p in %0d cycles want %p", z, got_addr_q, cyc, exp_addr_q);
      end
    end
    zero = 0;
  endtask

  task automatic test_stall_wrap();
    int stall;
    int c;
    logic [7:0] cap_pc;
    logic [7:0] cap_instr;
    fill_halt();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h30; rom[8'hFF] = 8'h10;
    wait_states = 3;
    ready_en = 0;
    zero = 0;
    model_run(1'b0, 64);
    do_reset();
    stall = 0;
    cap_pc = 8'h00;
    cap_instr = 8'h00;
    c = 0;
    while (c < 500 && !halted) begin
      @(negedge clk);
      c++;
      if (instr_valid && !ready_en) begin
        if (stall == 0) begin
          cap_pc = pc_reg;
          cap_instr = instr;
        end else begin
          n_checks++;
          if (pc_reg !== cap_pc || instr !== cap_instr) begin
            n_fail++;
            $display("FAIL stall_hold: got pc=%h instr=%h want %h %h", pc_reg, instr, cap_pc, cap_instr);
          end
        end
        stall++;
        if (stall == 5) begin
          @(posedge clk);
          #2 ready_en = 1;
        end
      end
    end
    n_checks++;
    if (!halted || stall != 5 || got_instr_q.size() != 1 || cap_instr !== 8'h30 || cap_pc !== 8'hFF) begin
      n_fail++;
      $display("FAIL stall_issue: got halted=%b stalls=%0d issued=%0d instr=%h pc=%h, want 1 5 1 30 ff",
               halted, stall, got_instr_q.size(), cap_instr, cap_pc);
    end
    n_checks++;
    if (got_addr_q != exp_addr_q || pc_reg !== 8'h10) begin
      n_fail++;
      $display("FAIL wrap_seq: got %p pc=%h want %p pc=10", got_addr_q, pc_reg, exp_addr_q);
    end
    n_checks++;
    if (pc_err != 0 || instr_err != 0 || addr_err != 0) begin
      n_fail++;
      $display("FAIL wait_hold: got pc_err=%0d instr_err=%0d addr_err=%0d want 0", pc_err, instr_err, addr_err);
    end
    ready_en = 1;
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit ok;
    fill_halt();
    rom[0] = 8'h30; rom[1] = 8'h00; rom[2] = 8'h45;
    wait_states = 4;
    ready_en = 1;
    model_run(1'b0, 64);
    do_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_setup: got req=%b ack=%b want 1 0", mem_req, mem_ack);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || pc_load !== 1'b1 || pc_target !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: got req=%b load=%b target=%h want 0 1 00", mem_req, pc_load, pc_target);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_halt(400, cyc, ok);
    n_checks++;
    if (!ok || got_addr_q != exp_addr_q || got_instr_q != exp_instr_q) begin
      n_fail++;
      $display("FAIL midrst_restart: got halted=%b addrs=%p instrs=%p want %p %p",
               ok, got_addr_q, got_instr_q, exp_addr_q, exp_instr_q);
    end
    n_checks++;
    if (cyc != 2 + exp_addr_q.size() * 5 + exp_instr_q.size()) begin
      n_fail++;
      $display("FAIL midrst_latency: got %0d cycles want %0d", cyc, 2 + exp_addr_q.size() * 5 + exp_instr_q.size());
    end
  endtask

  task automatic test_random();
    int cyc;
    bit ok;
    int r;
    logic [3:0] op;
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 99);
        if (r < 3) op = 4'hF;
        else if (r < 25) op = 4'h0;
        else if (r < 40) op = 4'h1;
        else if (r < 55) op = 4'h2;
        else op = 4'($urandom_range(3, 14));
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      zero = 1'($urandom_range(0, 1));
      wait_states = $urandom_range(0, 2);
      ready_rand = 1;
      model_run(zero, 4000);
      do_reset();
      wait_halt(600, cyc, ok);
      n_checks++;
      if (got_addr_q.size() == 0 || got_addr_q.size() > exp_addr_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d fetches, model has %0d", run, got_addr_q.size(), exp_addr_q.size());
      end
      foreach (got_addr_q[i]) begin
        if (i < exp_addr_q.size()) begin
          n_checks++;
          if (got_addr_q[i] !== exp_addr_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_addr[%0d]: got %h want %h", run, i, got_addr_q[i], exp_addr_q[i]);
          end
        end
      end
      foreach (got_instr_q[i]) begin
        n_checks++;
        if (i >= exp_instr_q.size() || got_instr_q[i] !== exp_instr_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_instr[%0d]: got %h, model has %0d instrs", run, i, got_instr_q[i], exp_instr_q.size());
        end
      end
      if (ok) begin
        n_checks++;
        if (!m_halt || pc_reg !== m_pc || got_addr_q.size() != exp_addr_q.size()) begin
          n_fail++;
          $display("FAIL rand%0d_halt: got pc=%h fetches=%0d want pc=%h fetches=%0d",
                   run, pc_reg, got_addr_q.size(), m_pc, exp_addr_q.size());
        end
      end
      n_checks++;
      if (pc_err != 0 || instr_err != 0 || addr_err != 0) begin
        n_fail++;
        $display("FAIL rand%0d_hold: got pc_err=%0d instr_err=%0d addr_err=%0d want 0", run, pc_err, instr_err, addr_err);
      end
    end
    ready_rand = 0;
    zero = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight_line();
    test_jump();
    test_cond_jump();
    test_stall_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the 8-bit computer: the controlling side of the program counter. It drives the PC's `control`/`din` pair, reads program memory at the current PC over a req/ack handshake, resolves NOP/JMP/JZ/HLT locally, and hands every other opcode to the decoder through a valid/ready handshake. Because the PC has no reset and no enable, this block also forces the PC to 0x00 on reset and stalls it by reloading its own value.

## Interface
- `OP_NOP`, 4'h0: opcode[7:4] for no-op; single byte, skipped.
- `OP_JMP`, 4'h1: unconditional jump; second byte is the target.
- `OP_JZ`, 4'h2: jump if `zero`; second byte is the target.
- `OP_HLT`, 4'hF: halt until reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  8  current PC value (PC `dout`).
- `pc_load`  out  1  to PC `control`: 1 = load `pc_target`, 0 = increment.
- `pc_target`  out  8  to PC `din`.
- `mem_addr`  out  8  program memory address, always equal to `pc`.
- `mem_req`  out  1  read request.
- `mem_data`  in  8  read data, valid when `mem_req && mem_ack`.
- `mem_ack`  in  1  read complete; may be asserted in the first cycle of `mem_req`.
- `zero`  in  1  ALU zero flag, sampled when the JZ operand is accepted.
- `instr`  out  8  opcode byte for the decoder.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decoder accepts `instr`.
- `halted`  out  1  high in HALT.

## Operation
- States: START, FETCH, OPERAND, ISSUE, HALT. `rst` forces START asynchronously.
- `pc_load`/`pc_target` are combinational from state, `mem_ack`, `mem_data`, `zero`. Holding the PC means `pc_load=1`, `pc_target=pc`.
- START: `pc_load=1`, `pc_target=8'h00`. The PC is loaded with 0x00 on every edge while `rst` is high. The next state is FETCH.
- FETCH: `mem_req=1` and the PC is held until `mem_ack`. On ack, decode `mem_data[7:4]`:
  - NOP: `pc_load=0`; stay in FETCH.
  - JMP or JZ: latch the opcode; `pc_load=0` so the PC steps to the operand; go to OPERAND.
  - HLT: hold the PC; go to HALT.
  - Other: latch `mem_data` into `instr`; `pc_load=0`; go to ISSUE.
- OPERAND: `mem_req=1` and the PC is held until `mem_ack`. On ack:
  - If the latched opcode is JMP, or it is JZ and `zero=1`: `pc_load=1`, `pc_target=mem_data`.
  - Otherwise: `pc_load=0`, which skips the operand.
  - In both cases, go to FETCH.
- ISSUE: `instr_valid=1` and the PC is held. When `instr_ready=1`, go to FETCH. `instr` is stable while valid.
- HALT: the PC is held and `halted=1`. Only `rst` exits this state.
- Address arithmetic is 8-bit modulo. An opcode at 0xFF takes its operand from 0x00. A JMP target may be any value, including its own address.
- Reset values: state START, `mem_req=0`, `instr_valid=0`, `instr=8'h00`, `halted=0`, `pc_load=1`, `pc_target=8'h00`.
- If `rst` asserts mid-handshake, any pending memory read or instruction is dropped. The memory side must tolerate `mem_req` falling without an ack.

## Timing
- Fetch latency equals the memory wait states: ack in cycle N means the PC update lands at the edge ending cycle N.
- Zero-wait minimum cycles per instruction: NOP 1, ALU-type 2 (FETCH plus ISSUE), JMP/JZ 2, HLT 1.
- After `rst` deasserts, START lasts 1 cycle. FETCH begins with `pc=0x00`.
- `instr_valid` asserts the cycle after the FETCH ack and drops the cycle after the `instr_ready` handshake.
- The combinational path `mem_ack`/`mem_data` → `pc_load`/`pc_target` is the critical path.
- `mem_addr` is combinational from `pc`.
- `zero` is only sampled in OPERAND on the ack cycle.

## Test plan
- Reset: hold `rst` for 3 edges, then release. Required: `pc` = 0x00 and `mem_req` = 1 on the first FETCH cycle; `instr_valid` = 0 and `halted` = 0 throughout.
- Straight-line: ROM {0x00:8'h30, 0x01:8'h00, 0x02:8'h45}, zero-wait ack, `instr_ready` = 1. Required: `instr` 0x30 then 0x45; the NOP at 0x01 is skipped; `pc` ends at 0x03.
- Jump: ROM {0x00:8'h10, 0x01:8'h80, 0x80:8'hF0}. Required: PC sequence 0x00, 0x01, 0x80. `halted` = 1 and `pc` stays 0x80 for 20 cycles.
- Conditional jump: ROM {0x00:8'h20, 0x01:8'h40}.
  - With `zero` = 0: `pc` = 0x02 after the operand.
  - With `zero` = 1: `pc` = 0x40.
- Stalls and wrap: memory with 3 wait states, `instr_ready` low for 5 cycles. Required: `pc` and `instr` are stable while stalled. A JMP at 0xFF takes its target from 0x00.
- Mid-fetch reset: assert `rst` while `mem_req` = 1 and no ack has arrived. Required: `mem_req` = 0 immediately (asynchronous); fetch restarts at 0x00.
